// File: rtl/vga_timing_axis.sv
// vga_timing_axis: one axis of VGA timing (sync/back/active/front) with tick gating and cascadable wrap
module vga_timing_axis #(
  parameter int SYNC_PULSE = 96,
  parameter int BACK_PORCH = 48,
  parameter int ACTIVE = 640,
  parameter int FRONT_PORCH = 16,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  output logic                  sync,
  output logic                  active,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  active_last,
  output logic                  wrap
);
  localparam int TOTAL = SYNC_PULSE + BACK_PORCH + ACTIVE + FRONT_PORCH;
  localparam int CW = $clog2(TOTAL);
  localparam logic [CW-1:0] SYNC_END = CW'(SYNC_PULSE - 1);
  localparam logic [CW-1:0] ACT_START = CW'(SYNC_PULSE + BACK_PORCH);
  localparam logic [CW-1:0] BACK_END = CW'(SYNC_PULSE + BACK_PORCH - 1);
  localparam logic [CW-1:0] ACT_END = CW'(SYNC_PULSE + BACK_PORCH + ACTIVE - 1);
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_BACK = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_FRONT = 2'd3;

  if (2 ** ADDR_WIDTH < ACTIVE + 1) begin : g_bad_addr_width
    $error("vga_timing_axis: ADDR_WIDTH too small for ACTIVE");
  end

  logic [CW-1:0] count, count_nxt, rel;
  logic [1:0] state, state_nxt;

  // wrap is purely combinational so a downstream axis steps on the same edge
  assign wrap = tick && count == LAST;
  assign rel = count - ACT_START;

  always_comb begin
    count_nxt = !tick ? count : count == LAST ? '0 : count + CW'(1);
    state_nxt = !tick ? state :
                (state == S_SYNC && count == SYNC_END) ? S_BACK :
                (state == S_BACK && count == BACK_END) ? S_ACTIVE :
                (state == S_ACTIVE && count == ACT_END) ? S_FRONT :
                (state == S_FRONT && count == LAST) ? S_SYNC : state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      state <= S_SYNC;
      sync <= SYNC_ACTIVE_LOW;
      active <= 1'b0;
      addr <= '1;
      active_last <= 1'b0;
    end else begin
      count <= count_nxt;
      state <= state_nxt;
      sync <= (state == S_SYNC) ? !SYNC_ACTIVE_LOW : SYNC_ACTIVE_LOW;
      active <= state == S_ACTIVE;
      addr <= (state == S_ACTIVE) ? ADDR_WIDTH'(rel) : '1;
      active_last <= state == S_ACTIVE && count == ACT_END;
    end
  end
endmodule

// File: tb/tb_vga_timing_axis.sv
// tb_vga_timing_axis: directed checks of horizontal, tiny and cascaded vertical timing axes
module tb_vga_timing_axis;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic h_tick = 1'b1;
  logic t_tick = 1'b1;
  logic h_sync, h_active, h_last, h_wrap;
  logic [9:0] h_addr;
  logic t_sync, t_active, t_last, t_wrap;
  logic [1:0] t_addr;
  logic v_sync, v_active, v_last, v_wrap;
  logic [8:0] v_addr;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_axis u_h (
    .clk(clk), .reset(reset), .tick(h_tick), .sync(h_sync), .active(h_active),
    .addr(h_addr), .active_last(h_last), .wrap(h_wrap)
  );

  vga_timing_axis #(.SYNC_PULSE(1), .BACK_PORCH(1), .ACTIVE(2), .FRONT_PORCH(1),
                    .SYNC_ACTIVE_LOW(1'b0), .ADDR_WIDTH(2)) u_t (
    .clk(clk), .reset(reset), .tick(t_tick), .sync(t_sync), .active(t_active),
    .addr(t_addr), .active_last(t_last), .wrap(t_wrap)
  );

  // vertical axis cascaded from the tiny axis: one line every 5 clocks
  vga_timing_axis #(.SYNC_PULSE(2), .BACK_PORCH(33), .ACTIVE(480), .FRONT_PORCH(10),
                    .SYNC_ACTIVE_LOW(1'b1), .ADDR_WIDTH(9)) u_v (
    .clk(clk), .reset(reset), .tick(t_wrap), .sync(v_sync), .active(v_active),
    .addr(v_addr), .active_last(v_last), .wrap(v_wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int t_sync_tbl[5] = '{1, 0, 0, 0, 0};
    int t_addr_tbl[5] = '{3, 3, 0, 1, 3};
    int h_bad = 0, t_bad = 0, v_bad = 0;
    int h_sync_low = 0, h_first_act = 0, h_wraps = 0, h_lasts = 0, h_last_addr = 0;
    int v_sync_low = 0, v_first_act = 0, v_wraps = 0, v_acts = 0, v_lasts = 0;
    int found;
    step();
    step();
    check("rst_h_sync", h_sync, 1);
    check("rst_h_active", h_active, 0);
    check("rst_h_addr", h_addr, 10'h3ff);
    check("rst_h_last", h_last, 0);
    check("rst_h_wrap", h_wrap, 0);
    check("rst_t_sync", t_sync, 0);
    check("rst_t_addr", t_addr, 3);
    check("rst_v_addr", v_addr, 9'h1ff);
    reset = 1'b0;
    for (int k = 1; k <= 5250; k++) begin
      int hc, tc, vc;
      step();
      hc = (k - 1) % 800;
      tc = (k - 1) % 5;
      vc = ((k - 1) / 5) % 525;
      if (h_sync !== (hc >= 96) || h_active !== (hc >= 144 && hc < 784) ||
          h_addr !== ((hc >= 144 && hc < 784) ? 10'(hc - 144) : 10'h3ff) ||
          h_last !== (hc == 783) || h_wrap !== (k % 800 == 799)) h_bad++;
      if (t_sync !== 1'(t_sync_tbl[tc]) || t_addr !== 2'(t_addr_tbl[tc]) ||
          t_active !== (tc == 2 || tc == 3) || t_last !== (tc == 3) || t_wrap !== (k % 5 == 4)) t_bad++;
      if (v_sync !== (vc >= 2) || v_active !== (vc >= 35 && vc < 515) ||
          v_addr !== ((vc >= 35 && vc < 515) ? 9'(vc - 35) : 9'h1ff) ||
          v_last !== (vc == 514) || v_wrap !== (k % 2625 == 2624)) v_bad++;
      if (k <= 800) begin
        if (!h_sync) h_sync_low++;
        if (h_active && h_first_act == 0) h_first_act = k;
        if (h_wrap) h_wraps++;
        if (h_last) begin h_lasts++; h_last_addr = int'(h_addr); end
      end
      if (k <= 10) begin
        check($sformatf("t_sync_k%0d", k), t_sync, t_sync_tbl[tc]);
        check($sformatf("t_addr_k%0d", k), t_addr, t_addr_tbl[tc]);
      end
      if (!v_sync) v_sync_low++;
      if (v_active) v_acts++;
      if (v_active && v_first_act == 0) v_first_act = k;
      if (v_wrap) v_wraps++;
      if (v_last) v_lasts++;
    end
    check("h_cycle_model", h_bad, 0);
    check("t_cycle_model", t_bad, 0);
    check("v_cycle_model", v_bad, 0);
    check("h_sync_low_len", h_sync_low, 96);
    check("h_active_rise", h_first_act, 145);
    check("h_wrap_per_line", h_wraps, 1);
    check("h_last_count", h_lasts, 1);
    check("h_last_addr", h_last_addr, 639);
    check("v_sync_low_clks", v_sync_low, 20);
    check("v_active_rise", v_first_act, 176);
    check("v_active_clks", v_acts, 4800);
    check("v_wrap_count", v_wraps, 2);
    check("v_last_clks", v_lasts, 10);
    // drop tick on the edge that would leave counter 444, so addr freezes at 300
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      if (h_active && h_addr == 10'd299) found = 1;
    end
    check("find_addr_299", found, 1);
    h_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("hold_addr_%0d", i), h_addr, 300);
      check($sformatf("hold_active_%0d", i), h_active, 1);
      check($sformatf("hold_sync_%0d", i), h_sync, 1);
      check($sformatf("hold_wrap_%0d", i), h_wrap, 0);
    end
    h_tick = 1'b1;
    step();
    check("resume_addr_0", h_addr, 300);
    step();
    check("resume_addr_1", h_addr, 301);
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      if (h_active && h_addr == 10'd500) found = 1;
    end
    check("find_addr_500", found, 1);
    reset = 1'b1;
    step();
    check("midrst_sync", h_sync, 1);
    check("midrst_active", h_active, 0);
    check("midrst_addr", h_addr, 10'h3ff);
    check("midrst_t_sync", t_sync, 0);
    reset = 1'b0;
    h_bad = 0;
    for (int k = 1; k <= 200; k++) begin
      int hc;
      step();
      hc = k - 1;
      if (k == 1) check("post_rst_sync", h_sync, 0);
      if (k == 144) check("post_rst_pre_active", h_active, 0);
      if (k == 145) begin
        check("post_rst_active", h_active, 1);
        check("post_rst_addr0", h_addr, 0);
      end
      if (h_sync !== (hc >= 96) || h_active !== (hc >= 144) ||
          h_addr !== ((hc >= 144) ? 10'(hc - 144) : 10'h3ff)) h_bad++;
    end
    check("post_rst_model", h_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
